// File: rtl/tdm_demux4.sv
// tdm_demux4: splits a 4-slot TDM stream back into 4 parallel channels with sync hunt/confirm/lock.
// Defining TDM_DEMUX_PARITY_EN adds in_par/par_err and drops frames that contain a parity fault.
module tdm_demux4 #(
    parameter int WIDTH       = 1,
    parameter int LOCK_FRAMES = 2,
    parameter int LOSS_FRAMES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_sof,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic               in_par,
    output logic               par_err,
`endif
    output logic [4*WIDTH-1:0] out_data,
    output logic               out_valid,
    output logic               locked,
    output logic               sync_err
);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam int BW = $clog2(LOSS_FRAMES + 1);

    typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [1:0]         slot_q, slot_d;
    logic [GW-1:0]      good_q, good_d;
    logic [BW-1:0]      bad_q, bad_d;
    logic [3*WIDTH-1:0] stage_q, stage_d;
    logic [4*WIDTH-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               serr_q, serr_d;
    logic               at0, sync_ok, store, frame_ok;
    logic [1:0]         wslot;

    assign at0       = slot_q == 2'd0;
    assign sync_ok   = in_sof == at0;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign locked    = state_q == LOCKED;
    assign sync_err  = serr_q;

`ifdef TDM_DEMUX_PARITY_EN
    logic par_fail, frame_start, perr_q, badf_q, badf_d;

    assign par_fail    = in_valid && ^{in_data, in_par};
    assign frame_start = in_valid && (state_q == HUNT ? in_sof : state_q == CONFIRM ? (at0 || in_sof) : at0);
    assign frame_ok    = !(badf_q || par_fail);
    assign par_err     = perr_q;

    // Sticky parity-fault flag for the frame being staged; restarts on every slot-0 beat.
    always_comb begin
        badf_d = badf_q;
        if (frame_start)
            badf_d = par_fail;
        else if (in_valid)
            badf_d = badf_q || par_fail;
    end

    // Parity pulse and frame flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
            badf_q <= 1'b0;
        end else begin
            perr_q <= par_fail;
            badf_q <= badf_d;
        end
    end
`else
    assign frame_ok = 1'b1;
`endif

    // Sync FSM, slot counter, staging writes and frame delivery; idle cycles change nothing.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        good_d  = good_q;
        bad_d   = bad_q;
        stage_d = stage_q;
        data_d  = data_q;
        valid_d = 1'b0;
        serr_d  = 1'b0;
        store   = 1'b0;
        wslot   = slot_q;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (in_sof) begin
                        store   = 1'b1;
                        wslot   = 2'd0;
                        slot_d  = 2'd1;
                        good_d  = GW'(1);
                        bad_d   = '0;
                        state_d = (LOCK_FRAMES == 1) ? LOCKED : CONFIRM;
                    end
                end
                CONFIRM: begin
                    store  = 1'b1;
                    slot_d = slot_q + 2'd1;
                    if (sync_ok) begin
                        if (at0) begin
                            good_d = good_q + 1'b1;
                            if (good_q == GW'(LOCK_FRAMES - 1))
                                state_d = LOCKED;
                        end
                    end else if (in_sof) begin
                        wslot  = 2'd0;
                        slot_d = 2'd1;
                        good_d = GW'(1);
                    end else begin
                        state_d = HUNT;
                    end
                end
                default: begin
                    store  = 1'b1;
                    slot_d = slot_q + 2'd1;
                    if (!sync_ok) begin
                        serr_d = 1'b1;
                        bad_d  = bad_q + 1'b1;
                        if (bad_q == BW'(LOSS_FRAMES - 1))
                            state_d = HUNT;
                    end else if (at0) begin
                        bad_d = '0;
                    end
                    if (slot_q == 2'd3 && frame_ok) begin
                        valid_d = 1'b1;
                        data_d  = {in_data, stage_q};
                    end
                end
            endcase
        end
        if (store)
            for (int k = 0; k < 3; k++)
                if (wslot == 2'(k))
                    stage_d[k*WIDTH +: WIDTH] = in_data;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            slot_q  <= 2'd0;
            good_q  <= '0;
            bad_q   <= '0;
            stage_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            stage_q <= stage_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            serr_q  <= serr_d;
        end
    end
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: self-checking bench for tdm_demux4 (vector table, directed sequences, random stream vs model).
module tb_tdm_demux4;
    localparam int LOCK = 2;
    localparam int LOSS = 2;

    logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
    logic [0:0] in_data = 1'b0;
    logic [3:0] out_data;
    logic       out_valid, locked, sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic       in_par = 1'b0, par_err, corrupt = 1'b0;
`endif
    int checks = 0, errors = 0, nval = 0, nserr = 0;

    tdm_demux4 #(.WIDTH(1), .LOCK_FRAMES(LOCK), .LOSS_FRAMES(LOSS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_sof(in_sof),
`ifdef TDM_DEMUX_PARITY_EN
        .in_par(in_par),
        .par_err(par_err),
`endif
        .out_data(out_data),
        .out_valid(out_valid),
        .locked(locked),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=hunting, 1=confirming, 2=locked; pos = slot expected next.
    int         m_mode, m_pos, m_good, m_bad;
    logic       m_buf [4];
    logic       m_badf, e_valid, e_serr, e_perr;
    logic [3:0] e_data;

    typedef struct {
        logic v, s, d, ev, el, es;
        logic [3:0] ed;
    } vec_t;
    vec_t tbl [16];

    function automatic vec_t mk(logic v, logic s, logic d, logic ev, logic el, logic es, logic [3:0] ed);
        vec_t r;
        r.v = v; r.s = s; r.d = d; r.ev = ev; r.el = el; r.es = es; r.ed = ed;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_good = 0; m_bad = 0; m_badf = 1'b0;
        e_valid = 1'b0; e_serr = 1'b0; e_perr = 1'b0; e_data = 4'h0;
        for (int i = 0; i < 4; i++) m_buf[i] = 1'b0;
    endtask

    task automatic model_beat(input logic s, input logic d, input logic f);
        int  wpos;
        bit  was_locked;
        wpos = -1;
        was_locked = (m_mode == 2);
        e_valid = 1'b0; e_serr = 1'b0; e_perr = f;
        if (m_mode == 0) begin
            if (s) begin
                wpos = 0; m_good = 1; m_bad = 0;
                m_mode = (m_good >= LOCK) ? 2 : 1;
            end
        end else if (m_mode == 1) begin
            if (s == (m_pos == 0)) begin
                wpos = m_pos;
                if (m_pos == 0) begin
                    m_good++;
                    if (m_good >= LOCK) m_mode = 2;
                end
            end else if (s) begin
                wpos = 0; m_good = 1;
            end else begin
                m_mode = 0;
            end
        end else begin
            wpos = m_pos;
            if (s != (m_pos == 0)) begin
                e_serr = 1'b1;
                m_bad++;
                if (m_bad >= LOSS) m_mode = 0;
            end else if (m_pos == 0) begin
                m_bad = 0;
            end
        end
        if (wpos >= 0) begin
            m_buf[wpos] = d;
            m_badf = (wpos == 0) ? f : (m_badf | f);
            m_pos = (wpos + 1) % 4;
        end else begin
            m_badf = m_badf | f;
        end
        if (wpos == 3 && was_locked && !m_badf) begin
            e_valid = 1'b1;
            e_data = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
        end
    endtask

    task automatic cyc(input logic v, input logic s, input logic d);
        logic f;
        f = 1'b0;
        in_valid = v; in_sof = s; in_data = d;
`ifdef TDM_DEMUX_PARITY_EN
        f = v && corrupt;
        in_par = d ^ corrupt;
`endif
        @(posedge clk);
        #1;
        if (v) model_beat(s, d, f);
        else begin
            e_valid = 1'b0; e_serr = 1'b0; e_perr = 1'b0;
        end
        check("out_valid", out_valid, e_valid);
        check("out_data", out_data, e_data);
        check("locked", locked, m_mode == 2);
        check("sync_err", sync_err, e_serr);
`ifdef TDM_DEMUX_PARITY_EN
        check("par_err", par_err, e_perr);
`endif
        if (out_valid) nval++;
        if (sync_err) nserr++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        #2;
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_sync_err", sync_err, 0);
`ifdef TDM_DEMUX_PARITY_EN
        check("rst_par_err", par_err, 0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // idle: 0 none, 1 after every beat, 2 randomly after beats
    task automatic send_frame(input logic [3:0] d, input logic [3:0] sofm, input int idle);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, sofm[k], d[k]);
            if (idle == 1 || (idle == 2 && $urandom_range(3) == 0)) cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int         r;
        logic [3:0] d, sm;
        tbl[0]  = mk(1, 1, 1, 0, 0, 0, 4'h0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 4'h0);
        tbl[2]  = mk(1, 0, 1, 0, 0, 0, 4'h0);
        tbl[3]  = mk(1, 0, 1, 0, 0, 0, 4'h0);
        tbl[4]  = mk(1, 1, 1, 0, 1, 0, 4'h0);
        tbl[5]  = mk(1, 0, 0, 0, 1, 0, 4'h0);
        tbl[6]  = mk(1, 0, 1, 0, 1, 0, 4'h0);
        tbl[7]  = mk(1, 0, 1, 1, 1, 0, 4'b1101);
        tbl[8]  = mk(1, 1, 1, 0, 1, 0, 4'b1101);
        tbl[9]  = mk(1, 0, 0, 0, 1, 0, 4'b1101);
        tbl[10] = mk(1, 0, 1, 0, 1, 0, 4'b1101);
        tbl[11] = mk(1, 0, 1, 1, 1, 0, 4'b1101);
        tbl[12] = mk(1, 0, 0, 0, 1, 1, 4'b1101);
        tbl[13] = mk(1, 0, 1, 0, 1, 0, 4'b1101);
        tbl[14] = mk(1, 0, 1, 0, 1, 0, 4'b1101);
        tbl[15] = mk(1, 0, 0, 1, 1, 0, 4'b0110);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].v, tbl[i].s, tbl[i].d);
            check("tbl_valid", out_valid, tbl[i].ev);
            check("tbl_data", out_data, tbl[i].ed);
            check("tbl_locked", locked, tbl[i].el);
            check("tbl_sync_err", sync_err, tbl[i].es);
        end

        do_reset();
        nval = 0;
        repeat (4) send_frame(4'b1101, 4'b0001, 1);
        check("idle_nval", nval, 3);
        check("idle_data", out_data, 4'b1101);

        do_reset();
        repeat (3) send_frame(4'b1101, 4'b0001, 0);
        nval = 0; nserr = 0;
        send_frame(4'b0110, 4'b0000, 0);
        check("drop1_serr", nserr, 1);
        check("drop1_locked", locked, 1);
        check("drop1_nval", nval, 1);
        send_frame(4'b1101, 4'b0001, 0);
        nval = 0; nserr = 0;
        send_frame(4'b0110, 4'b0000, 0);
        send_frame(4'b1001, 4'b0000, 0);
        check("drop2_serr", nserr, 2);
        check("drop2_locked", locked, 0);
        check("drop2_nval", nval, 1);
        nval = 0;
        send_frame(4'b1111, 4'b0000, 0);
        check("drop2_after_nval", nval, 0);

        do_reset();
        cyc(1, 1, 1); cyc(1, 0, 0); cyc(1, 1, 1);
        check("resync_confirm", locked, 0);
        cyc(1, 0, 0); cyc(1, 0, 1); cyc(1, 0, 1);
        check("resync_prelock", locked, 0);
        cyc(1, 1, 0);
        check("resync_lock", locked, 1);
        cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 0);
        check("resync_valid", out_valid, 1);
        check("resync_data", out_data, 4'b0110);

        do_reset();
        repeat (2) send_frame(4'b1101, 4'b0001, 0);
        cyc(1, 1, 0); cyc(1, 0, 1);
        do_reset();
        nval = 0;
        cyc(1, 0, 1); cyc(1, 0, 0);
        check("rstmid_nval", nval, 0);
        send_frame(4'b1101, 4'b0001, 0);
        check("rstmid_unlocked", locked, 0);
        cyc(1, 1, 1);
        check("rstmid_relock", locked, 1);
        cyc(1, 0, 0); cyc(1, 0, 1); cyc(1, 0, 1);
        check("rstmid_nval2", nval, 1);

`ifdef TDM_DEMUX_PARITY_EN
        do_reset();
        repeat (3) send_frame(4'b1101, 4'b0001, 0);
        nval = 0;
        cyc(1, 1, 0);
        corrupt = 1'b1;
        cyc(1, 0, 0);
        corrupt = 1'b0;
        check("par_pulse", par_err, 1);
        cyc(1, 0, 0); cyc(1, 0, 0);
        check("par_nval", nval, 0);
        check("par_hold", out_data, 4'b1101);
        send_frame(4'b0110, 4'b0001, 0);
        check("par_next_nval", nval, 1);
        check("par_next_data", out_data, 4'b0110);
`endif

        do_reset();
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(99));
            d = 4'($urandom);
            sm = 4'b0001;
            if (r < 6) sm = 4'b0000;
            else if (r < 11) sm = 4'(1 << $urandom_range(3, 1));
            else if (r < 15) repeat ($urandom_range(3, 1)) cyc(1'b1, 1'b0, 1'($urandom));
            else if (r < 16) do_reset();
`ifdef TDM_DEMUX_PARITY_EN
            corrupt = ($urandom_range(19) == 0);
`endif
            send_frame(d, sm, 2);
        end
`ifdef TDM_DEMUX_PARITY_EN
        corrupt = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
